// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock.
// Ports: Clk/Rst_n; Start, A, B in; Busy, Done, Quotient, Remainder, DivByZero out.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rmo_q;
    logic             dbz_q;

    logic [WIDTH:0]   shift_d;
    logic [WIDTH:0]   trial_d;
    logic             qbit_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] dvd_d;
    logic             accept_d;

    // The partial remainder is always below the divisor, so it is stored in
    // WIDTH bits; the extra bit exists only in the shifted and trial values.
    always_comb begin
        shift_d  = {rem_q, dvd_q[WIDTH-1]};
        trial_d  = shift_d - {1'b0, dvs_q};
        qbit_d   = ~trial_d[WIDTH];
        rem_d    = qbit_d ? trial_d[WIDTH-1:0] : shift_d[WIDTH-1:0];
        // Quotient bits fill the dividend register from the bottom as it
        // shifts out, so after WIDTH steps it holds the quotient.
        dvd_d    = {dvd_q[WIDTH-2:0], qbit_d};
        accept_d = Start && (state_q != RUN);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmo_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (accept_d) begin
                        dvd_q   <= A;
                        dvs_q   <= B;
                        rem_q   <= '0;
                        cnt_q   <= CW'(WIDTH - 1);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (dvs_q == '0) begin
                        quo_q   <= '1;
                        rmo_q   <= dvd_q;
                        dbz_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == '0) begin
                            quo_q   <= dvd_d;
                            rmo_q   <= rem_d;
                            dbz_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Quotient  = quo_q;
    assign Remainder = rmo_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and exhaustive checks of seq_divider (WIDTH=4).
// Expected results are queued at Start and compared when Done pulses.
module tb_seq_divider;

    localparam int W = 4;

    logic         Clk;
    logic         Rst_n;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         DivByZero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           a;
        int           b;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   accepts = 0;
    int   dones   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q = '1;
            e.r = W'(a);
            e.z = 1'b1;
        end else begin
            e.q = W'(a / b);
            e.r = W'(a % b);
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Called at a negedge; leaves the bench at the negedge after capture.
    task automatic start_op(input int a, input int b);
        Start = 1'b1;
        A     = W'(a);
        B     = W'(b);
        sb.push_back(model(a, b));
        accepts++;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // n counts edges since the capture edge; returns at the Done negedge.
    task automatic wait_done(input int n0, input int lat, input string tag);
        int n;
        n = n0;
        while (Done !== 1'b1 && n < lat + 6) begin
            chk({tag, "_busy"}, Busy, 1);
            @(negedge Clk);
            n++;
        end
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_busy_at_done"}, Busy, 0);
    endtask

    // Scoreboard: every Done pulse pops and compares one queued result.
    always @(negedge Clk) begin
        if (Rst_n === 1'b1 && Done === 1'b1) begin
            exp_t e;
            dones++;
            chk("done_expected", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("quo_%0d_%0d", e.a, e.b), Quotient, e.q);
                chk($sformatf("rem_%0d_%0d", e.a, e.b), Remainder, e.r);
                chk($sformatf("dbz_%0d_%0d", e.a, e.b), DivByZero, e.z);
            end
        end
    end

    initial begin
        Rst_n = 1'b0;
        Start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge Clk);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_quo", Quotient, 0);
        chk("rst_rem", Remainder, 0);
        chk("rst_dbz", DivByZero, 0);

        // Start already present at the first edge after release.
        Rst_n = 1'b1;
        start_op(13, 3);
        wait_done(0, 4, "d13_3");
        @(negedge Clk);
        chk("d13_3_done_pulse", Done, 0);
        chk("d13_3_hold_quo", Quotient, 4);
        chk("d13_3_hold_rem", Remainder, 1);

        start_op(15, 1);
        wait_done(0, 4, "d15_1");
        @(negedge Clk);
        start_op(3, 7);
        wait_done(0, 4, "d3_7");
        @(negedge Clk);
        start_op(15, 15);
        wait_done(0, 4, "d15_15");
        @(negedge Clk);
        start_op(5, 0);
        wait_done(0, 1, "d5_0");
        @(negedge Clk);
        chk("d5_0_done_pulse", Done, 0);
        chk("d5_0_hold_dbz", DivByZero, 1);

        // Start pulsed while busy must be ignored.
        start_op(12, 5);
        Start = 1'b1;
        A     = 4'd9;
        B     = 4'd2;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(1, 4, "d12_5");
        // Start held in the DONE cycle is accepted back-to-back.
        start_op(9, 2);
        chk("b2b_done_drop", Done, 0);
        chk("b2b_busy_rise", Busy, 1);
        wait_done(0, 4, "d9_2");
        @(negedge Clk);

        // Brief reset mid-run abandons the operation.
        start_op(14, 3);
        repeat (2) @(negedge Clk);
        #1 Rst_n = 1'b0;
        #1;
        chk("arst_busy", Busy, 0);
        chk("arst_done", Done, 0);
        chk("arst_quo", Quotient, 0);
        chk("arst_rem", Remainder, 0);
        chk("arst_dbz", DivByZero, 0);
        #1 Rst_n = 1'b1;
        accepts -= sb.size();
        sb.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            chk("arst_no_done", Done, 0);
        end
        start_op(14, 3);
        wait_done(0, 4, "d14_3");
        @(negedge Clk);

        // Exhaustive back-to-back sweep.
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                start_op(a, b);
                wait_done(0, (b == 0) ? 1 : 4, "sweep");
            end
        end
        @(negedge Clk);
        @(negedge Clk);
        chk("done_count", dones, accepts);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
